// File: rtl/mrc_digit_buffer.sv
// -----------------------------------------------------------------------------
// mrc_digit_buffer
//
// Collects results from the fixed-latency, non-stallable residue stage
// (modulus 177147) and presents them to a consumer through a valid/ready
// handshake. A token pipe remembers which issue cycles carried real operands,
// so only those result cycles are captured. Issue is throttled by credits
// (FIFO occupancy + tokens in flight), which means the FIFO cannot overflow
// even though upstream can never be stalled.
//
// Optional feature: define MRC_RANGE_CHECK_EN to add the sticky range_err
// output, flagging any captured residue >= MODULUS.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   issue_valid/last      operand issued upstream this cycle / final digit
//   issue_ready           upstream may issue this cycle (credit available)
//   mod_data_in           upstream result bus
//   out_valid/out_ready   head handshake
//   out_data/last/index   head residue digit, last flag, digit position
//   fifo_count            current FIFO occupancy
//   overflow_err          sticky; capture hit a full FIFO with no pop
//   range_err             (MRC_RANGE_CHECK_EN only) sticky; residue >= MODULUS
// -----------------------------------------------------------------------------
module mrc_digit_buffer #(
  parameter int DATA_WIDTH   = 18,
  parameter int MODULUS      = 177147,
  parameter int PIPE_LATENCY = 8,
  parameter int DEPTH        = 16,
  parameter int IDX_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic                    issue_last,
  output logic                    issue_ready,
  input  logic [DATA_WIDTH-1:0]   mod_data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last,
  output logic [IDX_WIDTH-1:0]    out_index,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    overflow_err
`ifdef MRC_RANGE_CHECK_EN
  ,
  output logic                    range_err
`endif
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_WIDTH + 1 + IDX_WIDTH;

  logic [PIPE_LATENCY-1:0] tok_vld_p;
  logic [PIPE_LATENCY-1:0] tok_last_p;
  logic [CNT_W-1:0]        inflight;
  logic [IDX_WIDTH-1:0]    idx_cnt;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [ENTRY_W-1:0]      mem [DEPTH];

  logic             issue_acc;
  logic             cap_valid;
  logic             cap_last;
  logic             fifo_full;
  logic             pop;
  logic             wr_en;
  logic [CNT_W:0]   credit_used;
  logic [ENTRY_W-1:0] head;

  // Credits come from registered state only; a pop frees its credit one
  // cycle later.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue_ready = credit_used < (CNT_W+1)'(DEPTH);
  assign issue_acc   = issue_valid & issue_ready;

  assign cap_valid = tok_vld_p[PIPE_LATENCY-1];
  assign cap_last  = tok_last_p[PIPE_LATENCY-1];

  assign fifo_full = (fifo_count == CNT_W'(DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  // When full, a simultaneous pop frees the slot being written (wr_ptr == rd_ptr).
  assign wr_en     = cap_valid & (~fifo_full | pop);

  // Head is gated so the outputs read zero whenever the FIFO is empty.
  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head[ENTRY_W-1 -: DATA_WIDTH];
  assign out_last  = head[IDX_WIDTH];
  assign out_index = head[IDX_WIDTH-1:0];

  // Token pipe: stage 0 is the issue cycle, last stage lines up with mod_data_in
  always_ff @(posedge clk) begin
    if (reset) begin
      tok_vld_p  <= '0;
      tok_last_p <= '0;
    end else begin
      tok_vld_p[0]  <= issue_acc;
      tok_last_p[0] <= issue_last;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        tok_vld_p[i]  <= tok_vld_p[i-1];
        tok_last_p[i] <= tok_last_p[i-1];
      end
    end
  end

  // Control state: inflight count, occupancy, pointers, digit index, error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight     <= '0;
      fifo_count   <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      idx_cnt      <= '0;
      overflow_err <= 1'b0;
    end else begin
      case ({issue_acc, cap_valid})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);

      // The index advances on every capture, even a dropped one, so the
      // numbering of later digits stays tied to their issue order.
      if (cap_valid) idx_cnt <= cap_last ? '0 : idx_cnt + IDX_WIDTH'(1);

      if (cap_valid && fifo_full && !pop) overflow_err <= 1'b1;
    end
  end

  // Storage: data only, never reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {mod_data_in, cap_last, idx_cnt};
  end

`ifdef MRC_RANGE_CHECK_EN
  localparam logic [DATA_WIDTH:0] MOD_LIM = (DATA_WIDTH+1)'(MODULUS);

  always_ff @(posedge clk) begin
    if (reset)
      range_err <= 1'b0;
    else if (cap_valid && ({1'b0, mod_data_in} >= MOD_LIM))
      range_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mrc_digit_buffer.sv
module tb_mrc_digit_buffer;

  localparam int DW    = 18;
  localparam int L     = 8;
  localparam int DEPTH = 16;
  localparam int MODV  = 177147;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_last = 1'b0;
  logic          issue_ready;
  logic [DW-1:0] mod_data_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [3:0]    out_index;
  logic [4:0]    fifo_count;
  logic          overflow_err;
`ifdef MRC_RANGE_CHECK_EN
  logic          range_err;
`endif

  mrc_digit_buffer #(
    .DATA_WIDTH(DW), .MODULUS(MODV), .PIPE_LATENCY(L), .DEPTH(DEPTH), .IDX_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_last(issue_last), .issue_ready(issue_ready),
    .mod_data_in(mod_data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .out_index(out_index),
    .fifo_count(fifo_count), .overflow_err(overflow_err)
`ifdef MRC_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: queue of words waiting for the consumer and a queue of
  // accepted issues, each with the cycle its result appears on mod_data_in.
  typedef struct { logic [DW-1:0] d; bit l; logic [3:0] i; } word_t;
  typedef struct { int due; bit l; } tok_t;
  word_t exp_q[$];
  tok_t  pend_q[$];
  logic [3:0] m_idx = '0;
  bit    m_ovf = 0;
  bit    m_rng = 0;
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  function automatic logic [DW-1:0] rnd_data();
    return DW'($urandom_range(0, (1 << DW) - 1));
  endfunction

  function automatic bit model_ready();
    return (exp_q.size() + pend_q.size()) < DEPTH;
  endfunction

  // Drive one cycle of inputs (called at a negedge) and advance the model.
  task automatic step(input bit iv, input bit il, input logic [DW-1:0] md, input bit ordy);
    bit mready, pop, cap, full, cl;
    word_t w;
    tok_t t;
    issue_valid = iv; issue_last = il; mod_data_in = md; out_ready = ordy;
    mready = model_ready();
    @(posedge clk);
    if (reset) begin
      exp_q.delete(); pend_q.delete(); m_idx = '0; m_ovf = 0; m_rng = 0;
    end else begin
      full = (exp_q.size() == DEPTH);
      pop  = (exp_q.size() > 0) && ordy;
      cap  = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      if (pop) void'(exp_q.pop_front());
      if (cap) begin
        cl = pend_q[0].l;
        void'(pend_q.pop_front());
        if (full && !pop) m_ovf = 1;
        else begin
          w.d = md; w.l = cl; w.i = m_idx;
          exp_q.push_back(w);
        end
        if (md >= DW'(MODV)) m_rng = 1;
        m_idx = cl ? 4'd0 : m_idx + 4'd1;
      end
      if (iv && mready) begin
        t.due = cyc + L; t.l = il;
        pend_q.push_back(t);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int k = 0; k < n; k++) step(0, 0, rnd_data(), ordy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2, 0);
    reset = 1'b0;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (out_data !== '0) $display("FAIL rst_out_data got=%0d exp=0", out_data); else n_pass++;
    n_chk++; if (out_last !== 1'b0 || out_index !== 4'd0)
      $display("FAIL rst_last_index got=%b/%0d exp=0/0", out_last, out_index); else n_pass++;
    n_chk++; if (fifo_count !== 5'd0) $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); else n_pass++;
    n_chk++; if (overflow_err !== 1'b0) $display("FAIL rst_overflow got=%b exp=0", overflow_err); else n_pass++;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL rst_issue_ready got=%b exp=1", issue_ready); else n_pass++;
  endtask

  task automatic test_single_digit();
    step(1, 1, rnd_data(), 1);
    idle(7, 1);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", out_valid); else n_pass++;
    step(0, 0, 18'd12345, 1);
    n_chk++; if (out_valid !== 1'b1 || out_data !== 18'd12345)
      $display("FAIL single_word got=%b/%0d exp=1/12345", out_valid, out_data); else n_pass++;
    n_chk++; if (out_last !== 1'b1 || out_index !== 4'd0)
      $display("FAIL single_tag got=%b/%0d exp=1/0", out_last, out_index); else n_pass++;
    n_chk++; if (fifo_count !== 5'd1) $display("FAIL single_count got=%0d exp=1", fifo_count); else n_pass++;
    idle(1, 1);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_popped got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1, (i == 4), rnd_data(), 1);
    idle(4, 1);
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || exp_q.size() == 0)
        $display("FAIL b2b_valid_%0d got=%b exp=1", i, out_valid);
      else if (out_index !== 4'(i) || out_last !== (i == 4) || out_data !== exp_q[0].d)
        $display("FAIL b2b_word_%0d got=%0d/%b/%0d exp=%0d/%b/%0d", i,
                 out_index, out_last, out_data, i, (i == 4), exp_q[0].d);
      else n_pass++;
      step(0, 0, rnd_data(), 1);
    end
    step(1, 1, rnd_data(), 1);
    idle(8, 1);
    n_chk++; if (out_valid !== 1'b1 || out_index !== 4'd0 || out_last !== 1'b1)
      $display("FAIL b2b_next_conv got=%b/%0d/%b exp=1/0/1", out_valid, out_index, out_last); else n_pass++;
    idle(2, 1);
  endtask

  task automatic test_backpressure_credit();
    int acc = 0;
    for (int i = 0; i < 24; i++) begin
      n_chk++; if (issue_ready !== model_ready())
        $display("FAIL credit_ready_cyc%0d got=%b exp=%b", i, issue_ready, model_ready()); else n_pass++;
      if (issue_ready === 1'b1) acc++;
      step(1, 0, rnd_data(), 0);
    end
    n_chk++; if (acc != DEPTH) $display("FAIL credit_accepted got=%0d exp=%0d", acc, DEPTH); else n_pass++;
    idle(10, 0);
    n_chk++; if (fifo_count !== 5'd16) $display("FAIL credit_full_count got=%0d exp=16", fifo_count); else n_pass++;
    n_chk++; if (overflow_err !== 1'b0) $display("FAIL credit_overflow got=%b exp=0", overflow_err); else n_pass++;
    n_chk++; if (issue_ready !== 1'b0) $display("FAIL credit_pop_cycle_ready got=%b exp=0", issue_ready); else n_pass++;
    step(0, 0, rnd_data(), 1);
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL credit_after_pop_ready got=%b exp=1", issue_ready); else n_pass++;
    n_chk++; if (fifo_count !== 5'd15) $display("FAIL credit_after_pop_count got=%0d exp=15", fifo_count); else n_pass++;
  endtask

  task automatic test_push_pop_same_cycle();
    step(1, 1, rnd_data(), 0);
    idle(7, 0);
    n_chk++; if (issue_ready !== 1'b0) $display("FAIL pp_ready_while_inflight got=%b exp=0", issue_ready); else n_pass++;
    step(0, 0, rnd_data(), 1);
    n_chk++; if (fifo_count !== 5'd15) $display("FAIL pp_count got=%0d exp=15", fifo_count); else n_pass++;
    for (int i = 0; i < 15; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || exp_q.size() == 0)
        $display("FAIL pp_drain_valid_%0d got=%b exp=1", i, out_valid);
      else if (out_data !== exp_q[0].d || out_index !== exp_q[0].i || out_last !== exp_q[0].l)
        $display("FAIL pp_drain_word_%0d got=%0d/%0d/%b exp=%0d/%0d/%b", i, out_data, out_index,
                 out_last, exp_q[0].d, exp_q[0].i, exp_q[0].l);
      else n_pass++;
      step(0, 0, rnd_data(), 1);
    end
    n_chk++; if (out_valid !== 1'b0 || overflow_err !== 1'b0)
      $display("FAIL pp_end got=%b/%b exp=0/0", out_valid, overflow_err); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) step(1, (i == 2), rnd_data(), 1);
    idle(3, 1);
    reset = 1'b1;
    idle(1, 1);
    reset = 1'b0;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL rmf_ready got=%b exp=1", issue_ready); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_chk++; if (out_valid !== 1'b0 || fifo_count !== 5'd0)
        $display("FAIL rmf_empty_%0d got=%b/%0d exp=0/0", i, out_valid, fifo_count); else n_pass++;
      idle(1, 1);
    end
  endtask

`ifdef MRC_RANGE_CHECK_EN
  task automatic test_range_check();
    step(1, 1, rnd_data(), 1);
    idle(7, 1);
    step(0, 0, 18'd177146, 1);
    n_chk++; if (range_err !== 1'b0 || out_data !== 18'd177146)
      $display("FAIL range_in got=%b/%0d exp=0/177146", range_err, out_data); else n_pass++;
    step(1, 1, rnd_data(), 1);
    idle(7, 1);
    step(0, 0, 18'd177147, 1);
    n_chk++; if (range_err !== 1'b1 || out_data !== 18'd177147)
      $display("FAIL range_out got=%b/%0d exp=1/177147", range_err, out_data); else n_pass++;
    idle(5, 1);
    n_chk++; if (range_err !== 1'b1) $display("FAIL range_sticky got=%b exp=1", range_err); else n_pass++;
    reset = 1'b1;
    idle(1, 1);
    reset = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_chk++;
      if (issue_ready !== model_ready() || out_valid !== (exp_q.size() > 0) ||
          fifo_count !== 5'(exp_q.size()) || overflow_err !== m_ovf)
        $display("FAIL rnd_ctrl_cyc%0d got=%b/%b/%0d/%b exp=%b/%b/%0d/%b", i, issue_ready, out_valid,
                 fifo_count, overflow_err, model_ready(), (exp_q.size() > 0), exp_q.size(), m_ovf);
      else n_pass++;
      if (exp_q.size() > 0) begin
        n_chk++;
        if (out_data !== exp_q[0].d || out_last !== exp_q[0].l || out_index !== exp_q[0].i)
          $display("FAIL rnd_head_cyc%0d got=%0d/%b/%0d exp=%0d/%b/%0d", i, out_data, out_last,
                   out_index, exp_q[0].d, exp_q[0].l, exp_q[0].i);
        else n_pass++;
      end
`ifdef MRC_RANGE_CHECK_EN
      n_chk++; if (range_err !== m_rng)
        $display("FAIL rnd_range_cyc%0d got=%b exp=%b", i, range_err, m_rng); else n_pass++;
`endif
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), rnd_data(),
           ($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_back_to_back();
    test_backpressure_credit();
    test_push_pop_same_cycle();
    test_reset_midflight();
`ifdef MRC_RANGE_CHECK_EN
    test_range_check();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
